perf_ctrl: RTL
==============

Name: perf_ctrl

Overview:
Sequencing controller for the `perf` performance monitor. It arms a measurement on a CSR command and converts the accelerator's `accel_start`/`accel_done` pulses into the monitor's `start_pulse`/`done_pulse`. When the monitor reports `measurement_done`, it collects the counts and accumulates them over N back-to-back runs into saturating snapshot registers. It sits between the CSR block, the tile scheduler and the `perf` instance, and raises an interrupt when the batch completes.

Parameters:
COUNTER_WIDTH, 32, width of the `perf` counter outputs.
ACC_WIDTH, 40, width of the accumulated snapshot registers (must be >= COUNTER_WIDTH).
RUN_WIDTH, 8, width of the run-count fields.
TIMEOUT_CYC, 1024, maximum cycles to wait for `perf_meas_done` after `perf_done_pulse`.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active low
csr_arm  in  1  one-cycle pulse; start a batch (honoured only in IDLE)
csr_clear  in  1  one-cycle pulse; abort, return to IDLE, clear snapshots and flags
csr_num_runs  in  RUN_WIDTH  runs per batch; sampled on arm; 0 is treated as 1
accel_start  in  1  pulse from the scheduler marking the start of an accelerator operation
accel_done  in  1  pulse marking the end of an accelerator operation
perf_start_pulse  out  1  drives `perf.start_pulse`
perf_done_pulse  out  1  drives `perf.done_pulse`
perf_total  in  COUNTER_WIDTH  `perf.total_cycles_count`
perf_active  in  COUNTER_WIDTH  `perf.active_cycles_count`
perf_idle  in  COUNTER_WIDTH  `perf.idle_cycles_count`
perf_meas_done  in  1  `perf.measurement_done`
snap_total  out  ACC_WIDTH  accumulated total cycles
snap_active  out  ACC_WIDTH  accumulated active cycles
snap_idle  out  ACC_WIDTH  accumulated idle cycles
runs_done  out  RUN_WIDTH  runs completed in the current or last batch
busy  out  1  high in every state except IDLE
irq  out  1  one-cycle pulse on batch completion
sat_flag  out  1  sticky; an accumulator saturated
timeout_flag  out  1  sticky; `perf_meas_done` did not arrive in time
proto_err  out  1  sticky; unexpected `accel_start` during MEASURE

Behaviour:
- Reset (async, `rst_n` = 0): state IDLE; every output and accumulator is 0.
- FSM states: IDLE, ARMED, MEASURE, WAIT_RES, ACCUM.
- Priority: `csr_clear` beats every other event in any state. It takes the FSM to IDLE next cycle and zeroes the snapshots, `runs_done` and all flags. No pulse outputs are emitted that cycle.
- IDLE:
  - On `csr_arm`: latch max(`csr_num_runs`, 1) into `target_runs`; zero the snapshots, `runs_done` and flags; go to ARMED.
  - `accel_start`/`accel_done` are ignored.
- ARMED:
  - On `accel_start`: `perf_start_pulse` = 1 for exactly the next cycle (registered, 1-cycle latency); go to MEASURE.
  - `accel_done` is ignored. If it coincides with `accel_start`, the start is taken and the done is dropped.
  - `csr_arm` is ignored.
- MEASURE:
  - On `accel_done`: `perf_done_pulse` = 1 for the next cycle; load the timeout counter with TIMEOUT_CYC; go to WAIT_RES.
  - On `accel_start` without `accel_done`: set `proto_err`, stay in MEASURE, emit no pulse.
  - The measured window is identical to the accel window, because both pulses are delayed by the same 1 cycle.
- WAIT_RES:
  - The timeout counter decrements each cycle.
  - On `perf_meas_done`: register `perf_total`, `perf_active` and `perf_idle`; go to ACCUM.
  - If the counter reaches 0 first: set `timeout_flag`, go to IDLE, leave `runs_done` unchanged, no `irq`.
- ACCUM (exactly 1 cycle):
  - Each snapshot becomes snap + zero-extended sample.
  - Saturation: if the sum exceeds 2^ACC_WIDTH-1, clamp to all-ones and set `sat_flag`. Each field saturates independently.
  - `runs_done` += 1. On the cycle this equals `target_runs`, go to IDLE, `busy` falls, and `irq` pulses once. Otherwise return to ARMED.
- Snapshot timing: snapshots update only in ACCUM and are stable otherwise; they remain readable in IDLE until the next arm or clear.
- Invariant: `perf_start_pulse` and `perf_done_pulse` are never high in the same cycle. Neither is ever wider than one cycle.
- Reset mid-operation: asynchronous return to the reset state; a pending pulse is cancelled immediately.

Test Plan:
1. Arm, num_runs=1; `accel_start`; `accel_done` 100 cycles later; busy stimulus always 1 -> snap_total=100, snap_active=100, snap_idle=0, runs_done=1, single `irq`, busy=0.
2. num_runs=3; windows of 50 (26 busy), 10 (0 busy), 100 (100 busy) -> snap_total=160, snap_active=126, snap_idle=34, one `irq` after the third run only.
3. num_runs=0; one 10-cycle window -> treated as 1 run, runs_done=1, `irq` pulses.
4. ACC_WIDTH=COUNTER_WIDTH=8; two 200-cycle windows busy -> snap_total=255, snap_active=255, sat_flag=1, runs_done=2.
5. Hold `perf_meas_done` low (stubbed `perf`), TIMEOUT_CYC=16 -> timeout_flag=1 exactly 16 cycles after `perf_done_pulse`; state IDLE; no `irq`; runs_done unchanged.
6. `csr_clear` mid-MEASURE, then a second `accel_start` during MEASURE in a fresh batch -> the clear zeroes everything and gives busy=0. In the fresh batch, proto_err=1 and no extra `perf_start_pulse` is emitted.

Source files
------------

// File: rtl/perf_ctrl.sv
// perf_ctrl: sequencing controller for the perf performance monitor.
// Arms a measurement batch on a CSR command and turns the accelerator
// start/done pulses into the monitor's start/done pulses. Each pulse is
// delayed by one cycle, so the measured window matches the accelerator
// window. After each run it collects the counts into saturating snapshot
// registers. It raises irq when all runs of the batch are done.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   csr_arm, csr_clear     CSR command pulses (clear has top priority)
//   csr_num_runs           runs per batch, sampled on arm (0 means 1)
//   accel_start/done       scheduler pulses delimiting one operation
//   perf_start/done_pulse  registered pulses into the perf instance
//   perf_total/active/idle counts from perf, sampled on perf_meas_done
//   snap_total/active/idle accumulated (saturating) counts
//   runs_done              runs completed in the current/last batch
//   busy, irq              not-idle status, batch-complete pulse
//   sat_flag, timeout_flag, proto_err  sticky status flags
module perf_ctrl #(
    parameter int COUNTER_WIDTH = 32,
    parameter int ACC_WIDTH     = 40,
    parameter int RUN_WIDTH     = 8,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     csr_arm,
    input  logic                     csr_clear,
    input  logic [RUN_WIDTH-1:0]     csr_num_runs,
    input  logic                     accel_start,
    input  logic                     accel_done,
    output logic                     perf_start_pulse,
    output logic                     perf_done_pulse,
    input  logic [COUNTER_WIDTH-1:0] perf_total,
    input  logic [COUNTER_WIDTH-1:0] perf_active,
    input  logic [COUNTER_WIDTH-1:0] perf_idle,
    input  logic                     perf_meas_done,
    output logic [ACC_WIDTH-1:0]     snap_total,
    output logic [ACC_WIDTH-1:0]     snap_active,
    output logic [ACC_WIDTH-1:0]     snap_idle,
    output logic [RUN_WIDTH-1:0]     runs_done,
    output logic                     busy,
    output logic                     irq,
    output logic                     sat_flag,
    output logic                     timeout_flag,
    output logic                     proto_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]     TMO_LOAD = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0]     TMO_ZERO = {TMO_W{1'b0}};
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};
    localparam logic [RUN_WIDTH-1:0] RUN_ZERO = {RUN_WIDTH{1'b0}};
    localparam logic [RUN_WIDTH-1:0] RUN_ONE  = RUN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_MEASURE  = 3'd2,
        S_WAIT_RES = 3'd3,
        S_ACCUM    = 3'd4
    } state_t;

    // Saturating add: MSB of the result flags saturation, the rest is the clamped sum.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0]     acc,
                                                   input logic [COUNTER_WIDTH-1:0] smp);
        logic [ACC_WIDTH:0] sum;
        sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - COUNTER_WIDTH){1'b0}}, smp};
        if (sum[ACC_WIDTH]) begin
            sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
        end else begin
            sat_add = sum;
        end
    endfunction

    state_t                   r_state, w_state_nxt;
    logic [RUN_WIDTH-1:0]     r_target, w_target_nxt;
    logic [RUN_WIDTH-1:0]     r_runs, w_runs_nxt;
    logic [TMO_W-1:0]         r_tmo, w_tmo_nxt;
    logic [COUNTER_WIDTH-1:0] r_samp_total, r_samp_active, r_samp_idle;
    logic [COUNTER_WIDTH-1:0] w_samp_total_nxt, w_samp_active_nxt, w_samp_idle_nxt;
    logic [ACC_WIDTH-1:0]     r_snap_total, r_snap_active, r_snap_idle;
    logic [ACC_WIDTH-1:0]     w_snap_total_nxt, w_snap_active_nxt, w_snap_idle_nxt;
    logic                     r_start_p, w_start_p_nxt;
    logic                     r_done_p, w_done_p_nxt;
    logic                     r_busy, r_irq, w_irq_nxt;
    logic                     r_sat, w_sat_nxt;
    logic                     r_tmo_flag, w_tmo_flag_nxt;
    logic                     r_proto, w_proto_nxt;
    logic [ACC_WIDTH:0]       w_add_total, w_add_active, w_add_idle;
    logic [RUN_WIDTH-1:0]     w_runs_inc;

    assign w_add_total  = sat_add(r_snap_total,  r_samp_total);
    assign w_add_active = sat_add(r_snap_active, r_samp_active);
    assign w_add_idle   = sat_add(r_snap_idle,   r_samp_idle);
    assign w_runs_inc   = r_runs + RUN_ONE;

    // Next-state, pulse and datapath decode; csr_clear overrides every state.
    always_comb begin
        w_state_nxt       = r_state;
        w_target_nxt      = r_target;
        w_runs_nxt        = r_runs;
        w_tmo_nxt         = r_tmo;
        w_samp_total_nxt  = r_samp_total;
        w_samp_active_nxt = r_samp_active;
        w_samp_idle_nxt   = r_samp_idle;
        w_snap_total_nxt  = r_snap_total;
        w_snap_active_nxt = r_snap_active;
        w_snap_idle_nxt   = r_snap_idle;
        w_start_p_nxt     = 1'b0;
        w_done_p_nxt      = 1'b0;
        w_irq_nxt         = 1'b0;
        w_sat_nxt         = r_sat;
        w_tmo_flag_nxt    = r_tmo_flag;
        w_proto_nxt       = r_proto;

        if (csr_clear) begin
            w_state_nxt       = S_IDLE;
            w_runs_nxt        = RUN_ZERO;
            w_tmo_nxt         = TMO_ZERO;
            w_snap_total_nxt  = ACC_ZERO;
            w_snap_active_nxt = ACC_ZERO;
            w_snap_idle_nxt   = ACC_ZERO;
            w_sat_nxt         = 1'b0;
            w_tmo_flag_nxt    = 1'b0;
            w_proto_nxt       = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (csr_arm) begin
                        w_target_nxt      = (csr_num_runs == RUN_ZERO) ? RUN_ONE : csr_num_runs;
                        w_runs_nxt        = RUN_ZERO;
                        w_snap_total_nxt  = ACC_ZERO;
                        w_snap_active_nxt = ACC_ZERO;
                        w_snap_idle_nxt   = ACC_ZERO;
                        w_sat_nxt         = 1'b0;
                        w_tmo_flag_nxt    = 1'b0;
                        w_proto_nxt       = 1'b0;
                        w_state_nxt       = S_ARMED;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ARMED: begin
                    // A done coinciding with start is dropped: start wins.
                    if (accel_start) begin
                        w_start_p_nxt = 1'b1;
                        w_state_nxt   = S_MEASURE;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end
                S_MEASURE: begin
                    if (accel_done) begin
                        w_done_p_nxt = 1'b1;
                        w_tmo_nxt    = TMO_LOAD;
                        w_state_nxt  = S_WAIT_RES;
                    end else if (accel_start) begin
                        w_proto_nxt = 1'b1;
                        w_state_nxt = S_MEASURE;
                    end else begin
                        w_state_nxt = S_MEASURE;
                    end
                end
                S_WAIT_RES: begin
                    // Counter at 1 means this decrement reaches 0: timeout.
                    if (perf_meas_done) begin
                        w_samp_total_nxt  = perf_total;
                        w_samp_active_nxt = perf_active;
                        w_samp_idle_nxt   = perf_idle;
                        w_tmo_nxt         = r_tmo - TMO_ONE;
                        w_state_nxt       = S_ACCUM;
                    end else if (r_tmo <= TMO_ONE) begin
                        w_tmo_nxt      = TMO_ZERO;
                        w_tmo_flag_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_tmo_nxt   = r_tmo - TMO_ONE;
                        w_state_nxt = S_WAIT_RES;
                    end
                end
                S_ACCUM: begin
                    w_snap_total_nxt  = w_add_total[ACC_WIDTH-1:0];
                    w_snap_active_nxt = w_add_active[ACC_WIDTH-1:0];
                    w_snap_idle_nxt   = w_add_idle[ACC_WIDTH-1:0];
                    w_sat_nxt         = r_sat | w_add_total[ACC_WIDTH]
                                      | w_add_active[ACC_WIDTH] | w_add_idle[ACC_WIDTH];
                    w_runs_nxt        = w_runs_inc;
                    if (w_runs_inc == r_target) begin
                        w_irq_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_target      <= RUN_ZERO;
            r_runs        <= RUN_ZERO;
            r_tmo         <= TMO_ZERO;
            r_samp_total  <= {COUNTER_WIDTH{1'b0}};
            r_samp_active <= {COUNTER_WIDTH{1'b0}};
            r_samp_idle   <= {COUNTER_WIDTH{1'b0}};
            r_snap_total  <= ACC_ZERO;
            r_snap_active <= ACC_ZERO;
            r_snap_idle   <= ACC_ZERO;
            r_start_p     <= 1'b0;
            r_done_p      <= 1'b0;
            r_busy        <= 1'b0;
            r_irq         <= 1'b0;
            r_sat         <= 1'b0;
            r_tmo_flag    <= 1'b0;
            r_proto       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_target      <= w_target_nxt;
            r_runs        <= w_runs_nxt;
            r_tmo         <= w_tmo_nxt;
            r_samp_total  <= w_samp_total_nxt;
            r_samp_active <= w_samp_active_nxt;
            r_samp_idle   <= w_samp_idle_nxt;
            r_snap_total  <= w_snap_total_nxt;
            r_snap_active <= w_snap_active_nxt;
            r_snap_idle   <= w_snap_idle_nxt;
            r_start_p     <= w_start_p_nxt;
            r_done_p      <= w_done_p_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_irq         <= w_irq_nxt;
            r_sat         <= w_sat_nxt;
            r_tmo_flag    <= w_tmo_flag_nxt;
            r_proto       <= w_proto_nxt;
        end
    end

    assign perf_start_pulse = r_start_p;
    assign perf_done_pulse  = r_done_p;
    assign snap_total       = r_snap_total;
    assign snap_active      = r_snap_active;
    assign snap_idle        = r_snap_idle;
    assign runs_done        = r_runs;
    assign busy             = r_busy;
    assign irq              = r_irq;
    assign sat_flag         = r_sat;
    assign timeout_flag     = r_tmo_flag;
    assign proto_err        = r_proto;

endmodule
